brc_pipe: RTL and testbench

//   Parametrised, pipelined branch comparator with valid/ready handshake.
//   - Splits the WIDTH-bit subtract-compare into STAGES chunks, LSB first.
//   - Borrow and running equality are registered between stages, so the

---
 rtl/brc_pipe.sv | 185 ++++++++++++++++++
 tb/tb_brc_pipe.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brc_pipe.sv
// Pipelined RV32 branch comparator with a valid/ready handshake.
// The subtract-compare is split into STAGES chunks, LSB first, with borrow and equality registered between them.
module brc_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [2:0]       i_br_op,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal,
  output logic             o_taken,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
);
  localparam int C  = WIDTH / STAGES;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  // Inter-stage registers: entry k holds the state after chunk k.
  logic             valid_q [NR];
  logic             valid_d [NR];
  logic [WIDTH-1:0] a_q     [NR];
  logic [WIDTH-1:0] a_d     [NR];
  logic [WIDTH-1:0] b_q     [NR];
  logic [WIDTH-1:0] b_d     [NR];
  logic [2:0]       op_q    [NR];
  logic [2:0]       op_d    [NR];
  logic [TAG_W-1:0] tag_q   [NR];
  logic [TAG_W-1:0] tag_d   [NR];
  logic             cout_q  [NR];
  logic             cout_d  [NR];
  logic             eq_q    [NR];
  logic             eq_d    [NR];

  logic             out_valid_q, out_valid_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             st_valid  [STAGES];
  logic [WIDTH-1:0] st_a      [STAGES];
  logic [WIDTH-1:0] st_b      [STAGES];
  logic [2:0]       st_op     [STAGES];
  logic [TAG_W-1:0] st_tag    [STAGES];
  logic             st_cin    [STAGES];
  logic             st_eq     [STAGES];
  logic             st_cout   [STAGES];
  logic             st_eq_out [STAGES];

  logic en;
  logic uns, ax, bx;

  assign en      = ~out_valid_q | i_ready;
  assign o_ready = en;

  always_comb begin
    st_valid[0] = i_valid & en;
    st_a[0]     = i_rs1_data;
    st_b[0]     = i_rs2_data;
    st_op[0]    = i_br_op;
    st_tag[0]   = i_tag;
    st_cin[0]   = 1'b1;
    st_eq[0]    = 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      st_valid[k] = valid_q[k-1];
      st_a[k]     = a_q[k-1];
      st_b[k]     = b_q[k-1];
      st_op[k]    = op_q[k-1];
      st_tag[k]   = tag_q[k-1];
      st_cin[k]   = cout_q[k-1];
      st_eq[k]    = eq_q[k-1];
    end
  end

  // Carry out of A_k + ~B_k + cin: no borrow when A_k > B_k, or A_k == B_k with no borrow coming in.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_cout[k]   = (st_a[k][k*C +: C] > st_b[k][k*C +: C]) |
                     ((st_a[k][k*C +: C] == st_b[k][k*C +: C]) & st_cin[k]);
      st_eq_out[k] = st_eq[k] & (st_a[k][k*C +: C] == st_b[k][k*C +: C]);
    end
  end

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      valid_d[k] = 1'b0;
      a_d[k]     = '0;
      b_d[k]     = '0;
      op_d[k]    = '0;
      tag_d[k]   = '0;
      cout_d[k]  = 1'b0;
      eq_d[k]    = 1'b0;
    end
    for (int k = 0; k < STAGES - 1; k++) begin
      valid_d[k] = st_valid[k];
      a_d[k]     = st_a[k];
      b_d[k]     = st_b[k];
      op_d[k]    = st_op[k];
      tag_d[k]   = st_tag[k];
      cout_d[k]  = st_cout[k];
      eq_d[k]    = st_eq_out[k];
    end
  end

  // Final stage: the sign of the (WIDTH+1)-bit difference gives "less"; illegal ops have op[1]=1 and so compare unsigned.
  always_comb begin
    uns         = st_op[STAGES-1][1];
    ax          = uns ? 1'b0 : st_a[STAGES-1][WIDTH-1];
    bx          = uns ? 1'b0 : st_b[STAGES-1][WIDTH-1];
    less_d      = ax ^ ~bx ^ st_cout[STAGES-1];
    equal_d     = st_eq_out[STAGES-1];
    illegal_d   = (st_op[STAGES-1][2:1] == 2'b01);
    out_valid_d = st_valid[STAGES-1];
    out_tag_d   = st_tag[STAGES-1];
    taken_d     = 1'b0;
    case (st_op[STAGES-1])
      3'b000:         taken_d = equal_d;
      3'b001:         taken_d = ~equal_d;
      3'b100, 3'b110: taken_d = less_d;
      3'b101, 3'b111: taken_d = ~less_d;
      default:        taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NR; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
        cout_q[k]  <= 1'b0;
        eq_q[k]    <= 1'b0;
      end
      out_valid_q <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      if (en) begin
        for (int k = 0; k < NR; k++) begin
          valid_q[k] <= valid_d[k];
          a_q[k]     <= a_d[k];
          b_q[k]     <= b_d[k];
          op_q[k]    <= op_d[k];
          tag_q[k]   <= tag_d[k];
          cout_q[k]  <= cout_d[k];
          eq_q[k]    <= eq_d[k];
        end
        out_valid_q <= out_valid_d;
        less_q      <= less_d;
        equal_q     <= equal_d;
        taken_q     <= taken_d;
        illegal_q   <= illegal_d;
        out_tag_q   <= out_tag_d;
      end
      if (i_flush) begin
        for (int k = 0; k < NR; k++) valid_q[k] <= 1'b0;
        out_valid_q <= 1'b0;
      end
    end
  end

  assign o_valid    = out_valid_q;
  assign o_br_less  = less_q;
  assign o_br_equal = equal_q;
  assign o_taken    = taken_q;
  assign o_illegal  = illegal_q;
  assign o_tag      = out_tag_q;

endmodule

// File: tb/tb_brc_pipe.sv
// Bench for brc_pipe: three instances (STAGES 1, 2, 4) share one input stream.
// Directed tests target the STAGES=2 instance; the random test scoreboards all three.
module tb_brc_pipe;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int N_RAND = 10000;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready;
  logic [W-1:0] rs1, rs2;
  logic [2:0] br_op;
  logic [TW-1:0] tag;

  logic o_ready_w [3];
  logic o_valid_w [3];
  logic less_w [3];
  logic equal_w [3];
  logic taken_w [3];
  logic illegal_w [3];
  logic [TW-1:0] tag_w [3];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  brc_pipe #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(o_ready_w[0]),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_op(br_op), .i_tag(tag), .o_valid(o_valid_w[0]),
    .i_ready(in_ready), .o_br_less(less_w[0]), .o_br_equal(equal_w[0]), .o_taken(taken_w[0]),
    .o_illegal(illegal_w[0]), .o_tag(tag_w[0]));

  brc_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) u_s2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(o_ready_w[1]),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_op(br_op), .i_tag(tag), .o_valid(o_valid_w[1]),
    .i_ready(in_ready), .o_br_less(less_w[1]), .o_br_equal(equal_w[1]), .o_taken(taken_w[1]),
    .o_illegal(illegal_w[1]), .o_tag(tag_w[1]));

  brc_pipe #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) u_s4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(o_ready_w[2]),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_br_op(br_op), .i_tag(tag), .o_valid(o_valid_w[2]),
    .i_ready(in_ready), .o_br_less(less_w[2]), .o_br_equal(equal_w[2]), .o_taken(taken_w[2]),
    .o_illegal(illegal_w[2]), .o_tag(tag_w[2]));

  // Observed result packed as {valid, less, equal, taken, illegal, tag}.
  function automatic logic [9:0] obs(input int i);
    return {o_valid_w[i], less_w[i], equal_w[i], taken_w[i], illegal_w[i], tag_w[i]};
  endfunction

  // Reference model: {less, equal, taken, illegal} from plain signed/unsigned compares.
  function automatic logic [3:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic less, equal, taken, illegal;
    illegal = (op == 3'b010) || (op == 3'b011);
    less    = op[1] ? (a < b) : ($signed(a) < $signed(b));
    equal   = (a == b);
    case (op)
      3'b000:         taken = equal;
      3'b001:         taken = !equal;
      3'b100, 3'b110: taken = less;
      3'b101, 3'b111: taken = !less;
      default:        taken = 1'b0;
    endcase
    return {less, equal, taken, illegal};
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    rs1      = '0;
    rs2      = '0;
    br_op    = '0;
    tag      = '0;
  endtask

  // Issue one op into an empty STAGES=2 pipe; report what is seen one and two cycles later.
  task automatic run_single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t, output logic [9:0] early, output logic [9:0] late);
    @(negedge clk);
    in_ready = 1'b1;
    in_valid = 1'b1;
    br_op = op; rs1 = a; rs2 = b; tag = t;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 early = obs(1);
    @(posedge clk);
    @(negedge clk);
    #1 late = obs(1);
  endtask

  task automatic test_reset();
    clear_inputs();
    in_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs(i) !== 10'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs inst %0d: got %h expected %h", i, obs(i), 10'd0);
      end
      n_checks++;
      if (o_ready_w[i] !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL reset_ready inst %0d: got %b expected 1", i, o_ready_w[i]);
      end
    end
  endtask

  task automatic test_blt();
    logic [9:0] e, l;
    run_single(3'b100, 32'hFFFF_FFFF, 32'h1, 5'd3, e, l);
    n_checks++;
    if (e[9] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL blt_early_valid: got %b expected 0", e[9]);
    end
    n_checks++;
    if (l !== {1'b1, 4'b1010, 5'd3}) begin
      n_fail++;
      $display("[TB] FAIL blt_result: got %h expected %h", l, {1'b1, 4'b1010, 5'd3});
    end
    run_single(3'b110, 32'hFFFF_FFFF, 32'h1, 5'd4, e, l);
    n_checks++;
    if (l !== {1'b1, 4'b0000, 5'd4}) begin
      n_fail++;
      $display("[TB] FAIL bltu_result: got %h expected %h", l, {1'b1, 4'b0000, 5'd4});
    end
  endtask

  task automatic test_chunk_boundary();
    logic [9:0] e, l;
    run_single(3'b101, 32'h0001_0000, 32'h0000_FFFF, 5'd5, e, l);
    n_checks++;
    if (l !== {1'b1, 4'b0010, 5'd5}) begin
      n_fail++;
      $display("[TB] FAIL bge_borrow: got %h expected %h", l, {1'b1, 4'b0010, 5'd5});
    end
    run_single(3'b000, 32'h8000_0000, 32'h8000_0000, 5'd6, e, l);
    n_checks++;
    if (l !== {1'b1, 4'b0110, 5'd6}) begin
      n_fail++;
      $display("[TB] FAIL beq_equal: got %h expected %h", l, {1'b1, 4'b0110, 5'd6});
    end
    run_single(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7, e, l);
    n_checks++;
    if (l !== {1'b1, 4'b0100, 5'd7}) begin
      n_fail++;
      $display("[TB] FAIL bne_equal: got %h expected %h", l, {1'b1, 4'b0100, 5'd7});
    end
  endtask

  task automatic test_illegal();
    logic [9:0] e, l;
    run_single(3'b010, 32'd5, 32'd3, 5'd8, e, l);
    n_checks++;
    if (l !== {1'b1, 4'b0001, 5'd8}) begin
      n_fail++;
      $display("[TB] FAIL illegal_010: got %h expected %h", l, {1'b1, 4'b0001, 5'd8});
    end
    run_single(3'b011, 32'd1, 32'hFFFF_FFFF, 5'd9, e, l);
    n_checks++;
    if (l !== {1'b1, 4'b1001, 5'd9}) begin
      n_fail++;
      $display("[TB] FAIL illegal_unsigned: got %h expected %h", l, {1'b1, 4'b1001, 5'd9});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    logic [9:0] held, expv;
    logic held_ok;
    int issued, delivered;
    ops = '{3'b100, 3'b001, 3'b111, 3'b000};
    issued = 0;
    delivered = 0;
    held_ok = 1'b0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      in_ready = !(c >= 3 && c <= 5);
      if (issued < 4) begin
        in_valid = 1'b1;
        br_op = ops[issued];
        rs1 = 32'(issued + 1) * 32'h1111;
        rs2 = 32'h2222;
        tag = 5'(issued + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (o_valid_w[1] && !in_ready) begin
        n_checks++;
        if (o_ready_w[1] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stall_ready: got %b expected 0", o_ready_w[1]);
        end
        if (held_ok) begin
          n_checks++;
          if (obs(1) !== held) begin
            n_fail++;
            $display("[TB] FAIL stall_hold: got %h expected %h", obs(1), held);
          end
        end
        held = obs(1);
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (o_valid_w[1] && in_ready) begin
        if (delivered < 4) begin
          expv = {1'b1, ref_result(ops[delivered], 32'(delivered + 1) * 32'h1111, 32'h2222), 5'(delivered + 1)};
          n_checks++;
          if (obs(1) !== expv) begin
            n_fail++;
            $display("[TB] FAIL b2b_order #%0d: got %h expected %h", delivered, obs(1), expv);
          end
        end
        delivered++;
      end
      if (in_valid && o_ready_w[1]) issued++;
    end
    n_checks++;
    if (delivered !== 4) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d results expected 4", delivered);
    end
  endtask

  task automatic test_flush();
    logic [9:0] e, l;
    int seen;
    @(negedge clk);
    in_ready = 1'b0;
    in_valid = 1'b1;
    br_op = 3'b000; rs1 = 32'd7; rs2 = 32'd7; tag = 5'd9;
    @(negedge clk);
    tag = 5'd10;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (obs(1) !== {1'b1, 4'b0110, 5'd9}) begin
      n_fail++;
      $display("[TB] FAIL flush_full: got %h expected %h", obs(1), {1'b1, 4'b0110, 5'd9});
    end
    flush = 1'b1;
    in_ready = 1'b1;
    in_valid = 1'b1;
    tag = 5'd11;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (o_valid_w[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_valid: got %b expected 0", o_valid_w[1]);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (o_valid_w[1] === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL flush_stale: got %0d results expected 0", seen);
    end
    run_single(3'b110, 32'd3, 32'hFFFF_FFFD, 5'd12, e, l);
    n_checks++;
    if (e[9] !== 1'b0 || l !== {1'b1, 4'b1010, 5'd12}) begin
      n_fail++;
      $display("[TB] FAIL flush_after: got %h/%h expected 0/%h", e[9], l, {1'b1, 4'b1010, 5'd12});
    end
  endtask

  task automatic test_reset_inflight();
    int seen;
    @(negedge clk);
    in_ready = 1'b1;
    in_valid = 1'b1;
    br_op = 3'b000; rs1 = 32'd1; rs2 = 32'd1; tag = 5'd13;
    @(negedge clk);
    tag = 5'd14;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_ready = 1'b0;
    #1;
    n_checks++;
    if (obs(1) !== 10'd0 || o_ready_w[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rst_inflight: got %h ready %b expected 000 ready 1", obs(1), o_ready_w[1]);
    end
    in_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      #1 if (o_valid_w[1] === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL rst_stale: got %0d results expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [8:0] sb0 [$];
    logic [8:0] sb1 [$];
    logic [8:0] sb2 [$];
    logic [8:0] expv, gotv;
    logic [9:0] o;
    logic [31:0] corners [5];
    logic [31:0] a, b;
    int acc [3];
    int sz, mode;
    bit done;
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    acc = '{0, 0, 0};
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      done = (acc[0] >= N_RAND) && (acc[1] >= N_RAND) && (acc[2] >= N_RAND);
      if (done && sb0.size() == 0 && sb1.size() == 0 && sb2.size() == 0) break;
      @(negedge clk);
      mode = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (mode)
        0: b = a;
        1: b = a ^ (32'h1 << $urandom_range(0, 31));
        2: begin a = corners[$urandom_range(0, 4)]; b = corners[$urandom_range(0, 4)]; end
        3: b = {a[31:16], b[15:0]};
        default: ;
      endcase
      rs1 = a;
      rs2 = b;
      br_op = 3'($urandom_range(0, 7));
      tag = 5'($urandom);
      in_valid = !done && ($urandom_range(0, 9) != 0);
      in_ready = done || ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (o_valid_w[i] && in_ready) begin
          case (i)
            0: sz = sb0.size();
            1: sz = sb1.size();
            default: sz = sb2.size();
          endcase
          n_checks++;
          if (sz == 0) begin
            n_fail++;
            $display("[TB] FAIL rand_spurious inst %0d: got tag %h expected no result", i, tag_w[i]);
          end else begin
            case (i)
              0: expv = sb0.pop_front();
              1: expv = sb1.pop_front();
              default: expv = sb2.pop_front();
            endcase
            o = obs(i);
            gotv = o[8:0];
            if (gotv !== expv) begin
              n_fail++;
              $display("[TB] FAIL rand_result inst %0d: got %h expected %h", i, gotv, expv);
            end
          end
        end
        if (in_valid && o_ready_w[i]) begin
          expv = {ref_result(br_op, rs1, rs2), tag};
          case (i)
            0: sb0.push_back(expv);
            1: sb1.push_back(expv);
            default: sb2.push_back(expv);
          endcase
          acc[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: sz = sb0.size();
        1: sz = sb1.size();
        default: sz = sb2.size();
      endcase
      n_checks++;
      if (acc[i] < N_RAND || sz != 0) begin
        n_fail++;
        $display("[TB] FAIL rand_drain inst %0d: got %0d accepted, %0d pending expected %0d, 0", i, acc[i], sz, N_RAND);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_blt();
    test_chunk_boundary();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
